// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: operands captured on start, one bit per clock LSB-first
// through a two-half-adder full-adder cell; result, carry and overflow published with done.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic load;
    logic step;
    logic last;
    logic ha0_s;
    logic ha0_c;
    logic ha1_s;
    logic ha1_c;
    logic carry_next;

    // Full adder from two half adders on the current LSBs
    assign ha0_s      = a_q[0] ^ b_q[0];
    assign ha0_c      = a_q[0] & b_q[0];
    assign ha1_s      = ha0_s ^ carry_q;
    assign ha1_c      = ha0_s & carry_q;
    assign carry_next = ha0_c | ha1_c;
    assign last       = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand shifters, carry flop, bit counter and the published result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            S       <= '0;
            C       <= 1'b0;
            V       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_d == RUN);
            done <= (state_d == DONE);
            if (load) begin
                a_q     <= A;
                b_q     <= sub ? ~B : B;
                carry_q <= sub ? 1'b1 : Cin;
                cnt_q   <= '0;
                acc_q   <= '0;
            end else if (step) begin
                a_q     <= {1'b0, a_q[WIDTH-1:1]};
                b_q     <= {1'b0, b_q[WIDTH-1:1]};
                acc_q   <= {ha1_s, acc_q[WIDTH-1:1]};
                carry_q <= carry_next;
                cnt_q   <= cnt_q + CW'(1);
                // carry_q here is the carry into the MSB
                if (last) begin
                    S <= {ha1_s, acc_q[WIDTH-1:1]};
                    C <= carry_next;
                    V <= carry_q ^ carry_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 scenarios plus an exhaustive WIDTH=4 sweep.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start8, sub8, cin8;
    logic [7:0] a8, b8, s8;
    logic       c8, v8, busy8, done8;

    logic       start4, sub4, cin4;
    logic [3:0] a4, b4, s4;
    logic       c4, v4, busy4, done4;

    int n_checks;
    int n_fail;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .A(a8), .B(b8), .Cin(cin8),
        .S(s8), .C(c8), .V(v8), .busy(busy8), .done(done8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .A(a4), .B(b4), .Cin(cin4),
        .S(s4), .C(c4), .V(v4), .busy(busy4), .done(done4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Launch one WIDTH=8 operation from posedge+1 and wait (bounded) for done
    task automatic do_run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic sb, output logic [7:0] s, output logic c,
                           output logic v, output int edges, output int bcyc);
        a8 = a; b8 = b; cin8 = cin; sub8 = sb; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        edges = 0;
        bcyc = 0;
        while (!done8 && edges < 20) begin
            if (busy8) bcyc++;
            @(posedge clk); #1;
            edges++;
        end
        s = s8; c = c8; v = v8;
    endtask

    task automatic do_run4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                           input logic sb, output logic [3:0] s, output logic c,
                           output logic v, output int edges);
        a4 = a; b4 = b; cin4 = cin; sub4 = sb; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        edges = 0;
        while (!done4 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        s = s4; c = c4; v = v4;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (s8 !== 8'h00) begin n_fail++; $display("FAIL reset_S: got %h expected 00", s8); end
        n_checks++;
        if ({c8, v8} !== 2'b00) begin n_fail++; $display("FAIL reset_CV: got %b expected 00", {c8, v8}); end
        n_checks++;
        if ({busy8, done8} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b expected 00", {busy8, done8}); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({busy8, done8, busy4, done4} !== 4'b0000) begin
            n_fail++; $display("FAIL idle_after_reset: got %b expected 0000", {busy8, done8, busy4, done4});
        end
    endtask

    task automatic test_basic_add;
        logic [7:0] s; logic c, v; int edges, bcyc;
        do_run8(8'h0F, 8'h01, 1'b0, 1'b0, s, c, v, edges, bcyc);
        n_checks++;
        if ({s, c, v} !== {8'h10, 2'b00}) begin n_fail++; $display("FAIL add_0F_01: got S=%h C=%b V=%b expected S=10 C=0 V=0", s, c, v); end
        n_checks++;
        if (edges !== 8) begin n_fail++; $display("FAIL add_latency: got %0d edges expected 8", edges); end
        n_checks++;
        if (bcyc !== 8) begin n_fail++; $display("FAIL add_busy_cycles: got %0d expected 8", bcyc); end
        @(posedge clk); #1;
        n_checks++;
        if ({busy8, done8} !== 2'b00) begin n_fail++; $display("FAIL done_one_cycle: got busy,done=%b expected 00", {busy8, done8}); end
    endtask

    task automatic test_carry_overflow;
        logic [7:0] va[3], vb[3], s;
        logic       vc[3];
        logic [9:0] vexp[3];
        logic c, v; int edges, bcyc;
        va = '{8'hFF, 8'h7F, 8'hFF};
        vb = '{8'h01, 8'h01, 8'h00};
        vc = '{1'b0, 1'b0, 1'b1};
        vexp = '{{8'h00, 2'b10}, {8'h80, 2'b01}, {8'h00, 2'b10}};
        for (int i = 0; i < 3; i++) begin
            do_run8(va[i], vb[i], vc[i], 1'b0, s, c, v, edges, bcyc);
            @(posedge clk); #1;
            n_checks++;
            if ({s, c, v} !== vexp[i] || edges !== 8) begin
                n_fail++;
                $display("FAIL carry_ovf_%0d: got S=%h C=%b V=%b edges=%0d expected S,C,V=%h,%b edges=8",
                         i, s, c, v, edges, vexp[i][9:2], vexp[i][1:0]);
            end
        end
    endtask

    task automatic test_subtract;
        logic [7:0] va[3], vb[3], s;
        logic       vc[3];
        logic [9:0] vexp[3];
        logic c, v; int edges, bcyc;
        va = '{8'h05, 8'h80, 8'h05};
        vb = '{8'h07, 8'h01, 8'h07};
        vc = '{1'b0, 1'b0, 1'b1};
        vexp = '{{8'hFE, 2'b00}, {8'h7F, 2'b11}, {8'hFE, 2'b00}};
        for (int i = 0; i < 3; i++) begin
            do_run8(va[i], vb[i], vc[i], 1'b1, s, c, v, edges, bcyc);
            @(posedge clk); #1;
            n_checks++;
            if ({s, c, v} !== vexp[i] || edges !== 8) begin
                n_fail++;
                $display("FAIL sub_%0d: got S=%h C=%b V=%b edges=%0d expected S,C,V=%h,%b edges=8",
                         i, s, c, v, edges, vexp[i][9:2], vexp[i][1:0]);
            end
        end
    endtask

    task automatic test_ignored_start;
        logic [7:0] prev;
        logic hold_ok;
        int edges;
        prev = s8;
        a8 = 8'h20; b8 = 8'h03; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        edges = 0;
        hold_ok = 1'b1;
        while (!done8 && edges < 20) begin
            if (s8 !== prev) hold_ok = 1'b0;
            if (edges == 2) begin
                a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        start8 = 1'b0;
        n_checks++;
        if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL s_hold_in_run: got changed S expected S=%h held", prev); end
        n_checks++;
        if ({s8, c8, v8} !== {8'h23, 2'b00} || edges !== 8) begin
            n_fail++; $display("FAIL ignored_start: got S=%h C=%b V=%b edges=%0d expected S=23 C=0 V=0 edges=8", s8, c8, v8, edges);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({busy8, done8} !== 2'b00) begin n_fail++; $display("FAIL no_queued_run: got busy,done=%b expected 00", {busy8, done8}); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] s; logic c, v; int edges, bcyc;
        logic hold_ok;
        do_run8(8'h10, 8'h20, 1'b0, 1'b0, s, c, v, edges, bcyc);
        n_checks++;
        if (s !== 8'h30) begin n_fail++; $display("FAIL b2b_first: got S=%h expected 30", s); end
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n_checks++;
        if ({busy8, done8} !== 2'b10) begin n_fail++; $display("FAIL b2b_no_idle: got busy,done=%b expected 10", {busy8, done8}); end
        edges = 0;
        hold_ok = 1'b1;
        while (!done8 && edges < 20) begin
            if (s8 !== 8'h30) hold_ok = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        n_checks++;
        if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_s_hold: got changed S expected 30 held"); end
        n_checks++;
        if ({s8, c8, v8} !== {8'h03, 2'b00} || edges !== 8) begin
            n_fail++; $display("FAIL b2b_second: got S=%h C=%b V=%b edges=%0d expected S=03 C=0 V=0 edges=8", s8, c8, v8, edges);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run;
        logic [7:0] s; logic c, v; int edges, bcyc;
        logic quiet;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({s8, c8, v8, busy8, done8} !== 12'h000) begin
            n_fail++; $display("FAIL reset_mid_run: got S=%h C=%b V=%b busy=%b done=%b expected all 0", s8, c8, v8, busy8, done8);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        quiet = 1'b1;
        repeat (12) begin
            if (done8 !== 1'b0 || busy8 !== 1'b0) quiet = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++;
        if (quiet !== 1'b1) begin n_fail++; $display("FAIL post_reset_quiet: got activity expected busy=0 done=0"); end
        do_run8(8'h33, 8'h11, 1'b0, 1'b0, s, c, v, edges, bcyc);
        n_checks++;
        if ({s, c, v} !== {8'h44, 2'b00} || edges !== 8) begin
            n_fail++; $display("FAIL post_reset_run: got S=%h C=%b V=%b edges=%0d expected S=44 C=0 V=0 edges=8", s, c, v, edges);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_exhaustive_w4;
        logic [3:0] a, b, s, es;
        logic cin, sb, c, v, ec, ev;
        int edges, ai, bi, ci, sa, sbv, res, sres, passes, shown;
        passes = 0;
        shown = 0;
        for (int k = 0; k < 1024; k++) begin
            a = k[3:0]; b = k[7:4]; cin = k[8]; sb = k[9];
            ai = int'(a); bi = int'(b); ci = int'(cin);
            sa = (ai >= 8) ? ai - 16 : ai;
            sbv = (bi >= 8) ? bi - 16 : bi;
            if (sb) begin
                res = ai - bi;
                ec = (ai >= bi);
                sres = sa - sbv;
            end else begin
                res = ai + bi + ci;
                ec = (res > 15);
                sres = sa + sbv + ci;
            end
            es = 4'(res & 15);
            ev = (sres < -8) || (sres > 7);
            do_run4(a, b, cin, sb, s, c, v, edges);
            n_checks++;
            if ({s, c, v} !== {es, ec, ev} || edges !== 4) begin
                n_fail++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL w4 A=%h B=%h Cin=%b sub=%b: got S=%h C=%b V=%b edges=%0d expected S=%h C=%b V=%b edges=4",
                             a, b, cin, sb, s, c, v, edges, es, ec, ev);
                end
            end else begin
                passes++;
            end
        end
        if (passes == 1024) $display("exhaustive WIDTH=4: %0d/1024 Pass", passes);
        else $display("exhaustive WIDTH=4: %0d/1024 Fail", passes);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
        test_reset();
        test_basic_add();
        test_carry_overflow();
        test_subtract();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_run();
        test_exhaustive_w4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised bit-serial adder/subtractor, the multi-bit sequential successor to the combinational half adder.
- Operands and carry-in are captured on a start pulse; one bit per clock is resolved LSB-first through a full-adder cell built from two half adders.
- The result, carry, and signed overflow are published with a one-cycle done strobe.
- Sits beside the adder cells as the area-minimal arithmetic option for narrow datapaths.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
sub  input  1  0 = A+B+Cin, 1 = A-B (A + ~B + 1; Cin ignored); captured with start
A  input  WIDTH  operand A, captured with start
B  input  WIDTH  operand B, captured with start
Cin  input  1  carry-in for add mode, captured with start
S  output  WIDTH  result, registered
C  output  1  carry-out (sub mode: 1 = no borrow)
V  output  1  signed two's-complement overflow = carry into MSB XOR carry out of MSB
busy  output  1  high while bits are being processed
done  output  1  one-cycle completion strobe

Behaviour:
- Interface: one clock (clk); asynchronous active-low reset (rst_n).
- States: IDLE, RUN, DONE.
- Reset (rst_n=0, any time, including mid-RUN):
  - Immediately forces state=IDLE.
  - S=0, C=0, V=0, busy=0, done=0.
  - Bit counter, operand shift registers and carry flop are cleared.
  - No partial result is ever published.
- IDLE --start=1--> RUN at edge E0:
  - Latch A, and B (or ~B if sub=1).
  - Initial carry = Cin (add) or 1 (sub).
  - Bit counter = 0; busy=1 from E0.
- RUN:
  - Each edge computes sum bit i = a_i ^ b_i ^ carry and carry' = majority(a_i, b_i, carry), then shifts both operands right, stores the sum bit into a working register, and increments the counter.
  - Carry into bit WIDTH-1 is held for V.
  - start is ignored while in RUN.
- RUN exit, at edge E0+WIDTH (last bit processed):
  - State -> DONE.
  - S, C, V are loaded from the working register and final carries.
  - done=1 and busy=0.
  - Latency: done is high in the cycle following exactly WIDTH edges after start was sampled.
- S/C/V hold the previous result throughout RUN and change only at the RUN->DONE edge. They then hold until the next completion or reset.
- DONE: done is high for exactly one cycle. On the next edge:
  - start=1 -> RUN, with new operands captured (back-to-back; done deasserts, busy=1).
  - Otherwise -> IDLE.
- Arithmetic is modulo 2^WIDTH. Counter width is clog2(WIDTH)+1 bits. Wrap past 0 or all-ones is signalled only via C and V.
- X on start/A/B is the bench's responsibility; no protection is required.

Test Plan (WIDTH=8 unless stated):
- Reset then idle:
  - Reset values: S=0x00, C=0, V=0, busy=0, done=0.
  - Add A=0x0F, B=0x01, Cin=0 -> S=0x10, C=0, V=0.
  - done rises exactly 8 edges after start is sampled; busy is high for those 8 cycles.
- Carry and overflow:
  - A=0xFF, B=0x01 -> S=0x00, C=1, V=0.
  - A=0x7F, B=0x01 -> S=0x80, C=0, V=1.
  - A=0xFF, B=0x00, Cin=1 -> S=0x00, C=1, V=0.
- Subtract:
  - A=0x05, B=0x07, sub=1 -> S=0xFE, C=0, V=0.
  - A=0x80, B=0x01, sub=1 -> S=0x7F, C=1, V=1.
  - Cin=1 during sub has no effect.
- Ignored start and back-to-back:
  - Pulse start with A=0xAA, B=0x55 mid-RUN -> ignored; the first result stands.
  - Assert start during DONE with A=0x01, B=0x02 -> next result S=0x03, with no IDLE cycle in between.
  - S holds the prior value throughout RUN.
- Reset mid-operation:
  - Drop rst_n asynchronously (off-edge) at bit 4 of a run -> all outputs are 0 immediately.
  - After release, no done is seen until a new start; a new run then completes correctly.
- Exhaustive check at WIDTH=4:
  - Cover all A, B, Cin, sub combinations (1024 runs) against a behavioural model.
  - Count passes and print Pass or Fail at the end, in the existing testbench style.
